// File: rtl/exponent_pkg.sv
// ============================================================================
// exponent_pkg : shared state encoding and default widths for exponent_sqm
// Rev 1.0
// ============================================================================
`default_nettype none

package exponent_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  localparam int C_BASE_W = 8;
  localparam int C_EXP_W  = 8;
  localparam int C_RES_W  = 32;

  // Value o_P and the running product take out of reset (X^0)
  localparam int C_P_RST  = 1;

endpackage

`default_nettype wire

// File: rtl/exponent_mul_ovf.sv
// ============================================================================
// exponent_mul_ovf : RES_W x RES_W multiply, low half plus upper-half-nonzero flag
// Rev 1.0
// ============================================================================
`default_nettype none

module exponent_mul_ovf #(
  parameter int RES_W = 32
) (
  input  logic [RES_W-1:0] i_a,
  input  logic [RES_W-1:0] i_b,
  output logic [RES_W-1:0] o_lo,
  output logic             o_ovf
);

  logic [2*RES_W-1:0] w_prod;

  assign w_prod = {{RES_W{1'b0}}, i_a} * {{RES_W{1'b0}}, i_b};
  assign o_lo   = w_prod[RES_W-1:0];
  assign o_ovf  = |w_prod[2*RES_W-1:RES_W];

endmodule

`default_nettype wire

// File: rtl/exponent_sqm.sv
// ============================================================================
// exponent_sqm : P = X^A by right-to-left square-and-multiply, start/done handshake
// Optional macro EXPONENT_SAT_EN saturates o_P to all ones on overflow. Rev 1.0
// ============================================================================
`default_nettype none

module exponent_sqm
  import exponent_pkg::*;
#(
  parameter int BASE_W = C_BASE_W,
  parameter int EXP_W  = C_EXP_W,
  parameter int RES_W  = C_RES_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [BASE_W-1:0] i_X,
  input  logic [EXP_W-1:0]  i_A,
  output logic              o_busy,
  output logic              o_done,
  output logic [RES_W-1:0]  o_P,
  output logic              o_ovf
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RES_W-1:0]   r_result;
  logic [RES_W-1:0]   r_base;
  logic [EXP_W-1:0]   r_exp;
  logic               r_res_ovf;
  logic               r_base_ovf;
  logic [RES_W-1:0]   w_mul_lo;
  logic               w_mul_ovf;
  logic [RES_W-1:0]   w_sq_lo;
  logic               w_sq_ovf;

  exponent_mul_ovf #(.RES_W(RES_W)) u_mul (
    .i_a   (r_result),
    .i_b   (r_base),
    .o_lo  (w_mul_lo),
    .o_ovf (w_mul_ovf)
  );

  exponent_mul_ovf #(.RES_W(RES_W)) u_sq (
    .i_a   (r_base),
    .i_b   (r_base),
    .o_lo  (w_sq_lo),
    .o_ovf (w_sq_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start)       w_state_nxt = ST_CALC;
      ST_CALC: if (r_exp == '0)   w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign o_busy = (r_state == ST_CALC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result   <= RES_W'(C_P_RST);
      r_base     <= '0;
      r_exp      <= '0;
      r_res_ovf  <= 1'b0;
      r_base_ovf <= 1'b0;
      o_done     <= 1'b0;
      o_P        <= RES_W'(C_P_RST);
      o_ovf      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_result   <= RES_W'(C_P_RST);
            r_base     <= RES_W'(i_X);
            r_exp      <= i_A;
            r_res_ovf  <= 1'b0;
            r_base_ovf <= 1'b0;
          end
        end
        ST_CALC: begin
          if (r_exp != '0) begin
            // An overflowed base only matters once it is folded into the result
            if (r_exp[0]) begin
              r_result  <= w_mul_lo;
              r_res_ovf <= r_res_ovf | w_mul_ovf | r_base_ovf;
            end
            r_base     <= w_sq_lo;
            r_base_ovf <= r_base_ovf | w_sq_ovf;
            r_exp      <= r_exp >> 1;
          end else begin
`ifdef EXPONENT_SAT_EN
            o_P    <= r_res_ovf ? '1 : r_result;
`else
            o_P    <= r_result;
`endif
            o_ovf  <= r_res_ovf;
            o_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
